// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch requester, the load/store requester, the
// arbiter and the single-ported program memory.
// slave  : arbiter side (takes requests and memory read data, drives the rest)
// master : requester/memory side
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [31:0]       if_rdata_o;
    logic              if_err_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [3:0]        d_be_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [31:0]       d_wdata_i;
    logic              d_gnt_o;
    logic              d_rvalid_o;
    logic [31:0]       d_rdata_o;
    logic              d_err_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-ported program memory between the
// instruction fetch port and the load/store port, one access per cycle,
// with a one-cycle response stage routing read data back to its owner.
// Out-of-range accesses are granted but answered with an error without
// strobing the memory.
// Optional macro IMEM_ARB_DATA_PRIORITY_EN: data always wins a tie (fixed
// priority, no round-robin pointer); default build is round-robin.
//
// Response owner register:
//   state    | meaning
//   OWN_NONE | no access in flight, no response this cycle
//   OWN_IF   | fetch access in flight, fetch response this cycle
//   OWN_D    | data access in flight, data response this cycle
module imem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    imem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(MEM_BYTES - 4);

    logic   w_if_sel;
    logic   w_d_sel;
    logic   w_if_oor;
    logic   w_d_oor;
    owner_t r_owner;
    owner_t w_owner_nxt;
    logic   r_err;
    logic   w_err_nxt;
    logic   r_wr;
    logic   w_wr_nxt;

    assign w_if_oor = (bus.if_addr_i > LP_MAX_ADDR);
    assign w_d_oor  = (bus.d_addr_i  > LP_MAX_ADDR);

`ifdef IMEM_ARB_DATA_PRIORITY_EN
    // Fixed priority grant: data wins every tie; gated off while in reset.
    always_comb begin
        w_d_sel  = rst_n_i & bus.d_req_i;
        w_if_sel = rst_n_i & bus.if_req_i & ~bus.d_req_i;
    end
`else
    logic r_last_d;

    // Round-robin grant: on a tie the port not served last time wins.
    always_comb begin
        w_if_sel = 1'b0;
        w_d_sel  = 1'b0;
        if (rst_n_i) begin
            if (bus.if_req_i && bus.d_req_i) begin
                w_if_sel = r_last_d;
                w_d_sel  = ~r_last_d;
            end else begin
                w_if_sel = bus.if_req_i;
                w_d_sel  = bus.d_req_i;
            end
        end
    end

    // Remember which port was granted last; fetch wins the first tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_d <= 1'b1;
        end else if (w_if_sel) begin
            r_last_d <= 1'b0;
        end else if (w_d_sel) begin
            r_last_d <= 1'b1;
        end
    end
`endif

    assign bus.if_gnt_o = w_if_sel;
    assign bus.d_gnt_o  = w_d_sel;

    // Drive the memory for an in-range granted access, otherwise all zero.
    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = 32'h0;
        if (w_if_sel && !w_if_oor) begin
            bus.mem_req_o  = 1'b1;
            bus.mem_be_o   = 4'hF;
            bus.mem_addr_o = bus.if_addr_i;
        end else if (w_d_sel && !w_d_oor) begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = bus.d_we_i;
            bus.mem_be_o    = bus.d_be_i;
            bus.mem_addr_o  = bus.d_addr_i;
            bus.mem_wdata_o = bus.d_wdata_i;
        end
    end

    // Capture owner, error and write flag of the access granted this cycle.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        w_err_nxt   = 1'b0;
        w_wr_nxt    = 1'b0;
        if (w_if_sel) begin
            w_owner_nxt = OWN_IF;
            w_err_nxt   = w_if_oor;
        end else if (w_d_sel) begin
            w_owner_nxt = OWN_D;
            w_err_nxt   = w_d_oor;
            w_wr_nxt    = bus.d_we_i;
        end
    end

    // Response stage register; reset drops any in-flight response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_owner <= OWN_NONE;
            r_err   <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_err   <= w_err_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    assign bus.if_rvalid_o = (r_owner == OWN_IF);
    assign bus.if_err_o    = (r_owner == OWN_IF) & r_err;
    assign bus.if_rdata_o  = ((r_owner == OWN_IF) && !r_err) ? bus.mem_rdata_i : 32'h0;

    assign bus.d_rvalid_o  = (r_owner == OWN_D);
    assign bus.d_err_o     = (r_owner == OWN_D) & r_err;
    assign bus.d_rdata_o   = ((r_owner == OWN_D) && !r_err && !r_wr) ? bus.mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the arbiter and memory.
module tb_imem_port_arbiter;
    localparam int MEM_BYTES = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.ADDR_W(32)) bus();

    imem_port_arbiter #(.ADDR_W(32), .MEM_BYTES(MEM_BYTES)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory device (responds to what the DUT drives) and reference copy.
    logic [7:0]  mem_arr [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic        sm_req = 1'b0, sm_we = 1'b0;
    logic [3:0]  sm_be = 4'h0;
    logic [31:0] sm_addr = 32'h0, sm_wdata = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_arr[(a + 32'(i)) % MEM_BYTES];
        return w;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[(a + 32'(i)) % MEM_BYTES];
        return w;
    endfunction

    function automatic bit oor(input logic [31:0] a);
        return {32'h0, a} > 64'(MEM_BYTES - 4);
    endfunction

    always @(negedge clk) begin
        sm_req   = bus.mem_req_o;
        sm_we    = bus.mem_we_o;
        sm_be    = bus.mem_be_o;
        sm_addr  = bus.mem_addr_o;
        sm_wdata = bus.mem_wdata_o;
    end

    always @(posedge clk) begin
        if (sm_req && !sm_we) bus.mem_rdata_i <= mem_word(sm_addr);
        else                  bus.mem_rdata_i <= $urandom;
        if (sm_req && sm_we)
            for (int i = 0; i < 4; i++)
                if (sm_be[i]) mem_arr[(sm_addr + 32'(i)) % MEM_BYTES] <= sm_wdata[8*i +: 8];
    end

    // Model state: who was served last and the one response owed next cycle.
    typedef struct {
        int          owner;   // 0 none, 1 fetch, 2 data
        bit          err;
        logic [31:0] data;
    } pend_t;

    bit    m_last_d = 1'b1;
    pend_t p = '{0, 1'b0, 32'h0};

    logic        o_if_gnt, o_d_gnt, o_if_rv, o_if_err, o_d_rv, o_d_err;
    logic        o_mem_req, o_mem_we;
    logic [3:0]  o_mem_be;
    logic [31:0] o_if_rd, o_d_rd, o_mem_addr, o_mem_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},  {30'h0, bus.if_gnt_o, bus.d_gnt_o}, 32'h0);
        chk({tag, "_rv"},   {28'h0, bus.if_rvalid_o, bus.if_err_o, bus.d_rvalid_o, bus.d_err_o}, 32'h0);
        chk({tag, "_rd"},   bus.if_rdata_o | bus.d_rdata_o, 32'h0);
        chk({tag, "_mem"},  {26'h0, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o}, 32'h0);
        chk({tag, "_madr"}, bus.mem_addr_o | bus.mem_wdata_o, 32'h0);
    endtask

    task automatic model_reset();
        m_last_d = 1'b1;
        p        = '{0, 1'b0, 32'h0};
    endtask

    // Called at posedge+1 with inputs already applied; checks, updates model.
    task automatic step();
        logic [31:0] ia, da;
        bit ifr, dr, eg_if, eg_d, e_mreq;
        logic [31:0] e_maddr, e_mwd;
        logic [3:0]  e_mbe;
        bit          e_mwe;
        ia = bus.if_addr_i;  da = bus.d_addr_i;
        ifr = bus.if_req_i;  dr = bus.d_req_i;
`ifdef IMEM_ARB_DATA_PRIORITY_EN
        eg_d  = dr;
        eg_if = ifr && !dr;
`else
        if (ifr && dr) begin
            eg_if = m_last_d;
            eg_d  = !m_last_d;
        end else begin
            eg_if = ifr;
            eg_d  = dr;
        end
`endif
        e_mreq  = (eg_if && !oor(ia)) || (eg_d && !oor(da));
        e_mwe   = e_mreq && eg_d && bus.d_we_i;
        e_mbe   = !e_mreq ? 4'h0 : (eg_if ? 4'hF : bus.d_be_i);
        e_maddr = !e_mreq ? 32'h0 : (eg_if ? ia : da);
        e_mwd   = (e_mreq && eg_d) ? bus.d_wdata_i : 32'h0;
        #3;
        o_if_gnt = bus.if_gnt_o;   o_d_gnt = bus.d_gnt_o;
        o_if_rv  = bus.if_rvalid_o; o_if_err = bus.if_err_o; o_if_rd = bus.if_rdata_o;
        o_d_rv   = bus.d_rvalid_o;  o_d_err  = bus.d_err_o;  o_d_rd  = bus.d_rdata_o;
        o_mem_req = bus.mem_req_o;  o_mem_we = bus.mem_we_o; o_mem_be = bus.mem_be_o;
        o_mem_addr = bus.mem_addr_o; o_mem_wd = bus.mem_wdata_o;
        chk("if_gnt",    o_if_gnt, eg_if);
        chk("d_gnt",     o_d_gnt, eg_d);
        chk("mem_req",   o_mem_req, e_mreq);
        chk("mem_we",    o_mem_we, e_mwe);
        chk("mem_be",    o_mem_be, e_mbe);
        chk("mem_addr",  o_mem_addr, e_maddr);
        chk("mem_wdata", o_mem_wd, e_mwd);
        chk("if_rvalid", o_if_rv, p.owner == 1);
        chk("if_err",    o_if_err, p.owner == 1 && p.err);
        chk("if_rdata",  o_if_rd, (p.owner == 1) ? p.data : 32'h0);
        chk("d_rvalid",  o_d_rv, p.owner == 2);
        chk("d_err",     o_d_err, p.owner == 2 && p.err);
        chk("d_rdata",   o_d_rd, (p.owner == 2) ? p.data : 32'h0);
        if (eg_if) begin
            m_last_d = 1'b0;
            p.owner  = 1;
            p.err    = oor(ia);
            p.data   = p.err ? 32'h0 : ref_word(ia);
        end else if (eg_d) begin
            m_last_d = 1'b1;
            p.owner  = 2;
            p.err    = oor(da);
            p.data   = (p.err || bus.d_we_i) ? 32'h0 : ref_word(da);
            if (!p.err && bus.d_we_i)
                for (int i = 0; i < 4; i++)
                    if (bus.d_be_i[i]) ref_mem[(da + 32'(i)) % MEM_BYTES] = bus.d_wdata_i[8*i +: 8];
        end else begin
            p.owner = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_i = 1'b0; bus.if_addr_i = 32'h0;
        bus.d_req_i = 1'b0;  bus.d_we_i = 1'b0; bus.d_be_i = 4'h0;
        bus.d_addr_i = 32'h0; bus.d_wdata_i = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        chk_all_zero("reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, MEM_BYTES/4 - 1)) * 4;
        else if (r == 7) return 32'($urandom_range(0, MEM_BYTES - 4));
        else if (r == 8) return 32'($urandom_range(MEM_BYTES - 3, MEM_BYTES + 80));
        else             return $urandom | 32'h8000_0000;
    endfunction

    logic [7:0] gseq, rvseq;
    logic [1:0] ga, gb;
    logic       mreq_any, saw_if_err, saw_d_err;

    initial begin
        clear_inputs();
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem_arr[i] = 8'($urandom);
            ref_mem[i] = mem_arr[i];
        end
        mem_arr[0] = 8'h03; mem_arr[1] = 8'h21; mem_arr[2] = 8'h40; mem_arr[3] = 8'h00;
        ref_mem[0] = 8'h03; ref_mem[1] = 8'h21; ref_mem[2] = 8'h40; ref_mem[3] = 8'h00;

        // Fetch only at address 0.
        do_reset();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0;
        step();
        chk("t1_if_gnt", o_if_gnt, 1);
        chk("t1_d_gnt", o_d_gnt, 0);
        bus.if_req_i = 1'b0;
        step();
        chk("t1_if_rvalid", o_if_rv, 1);
        chk("t1_if_rdata", o_if_rd, 32'h0040_2103);
        chk("t1_d_out", {o_d_rv, o_d_err, o_d_gnt} | o_d_rd, 0);

        // Both requesting continuously from reset.
        do_reset();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h4;
        bus.d_req_i = 1'b1;  bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h8;
        for (int k = 0; k < 4; k++) begin
            step();
            gseq[2*(3-k) +: 2]  = {o_if_gnt, o_d_gnt};
            rvseq[2*(3-k) +: 2] = {o_if_rv, o_d_rv};
        end
`ifdef IMEM_ARB_DATA_PRIORITY_EN
        chk("t2_grants", gseq, 8'b01_01_01_01);
        chk("t2_resps",  rvseq, 8'b00_01_01_01);
`else
        chk("t2_grants", gseq, 8'b10_01_10_01);
        chk("t2_resps",  rvseq, 8'b00_10_01_10);
`endif
        clear_inputs();
        step();

        // Partial-byte data write.
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_be_i = 4'b0011;
        bus.d_addr_i = 32'h30; bus.d_wdata_i = 32'hA5A5_1234;
        step();
        chk("t3_mem", {o_mem_req, o_mem_we, o_mem_be}, 6'b11_0011);
        chk("t3_mem_addr", o_mem_addr, 32'h30);
        chk("t3_mem_wdata", o_mem_wd, 32'hA5A5_1234);
        clear_inputs();
        step();
        chk("t3_d_rvalid", o_d_rv, 1);
        chk("t3_d_rdata", o_d_rd, 0);

        // Out-of-range fetch and data together.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h3FD;
        bus.d_req_i = 1'b1;  bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h400;
        saw_if_err = 1'b0; saw_d_err = 1'b0;
        step();
        ga = {o_if_gnt, o_d_gnt}; mreq_any = o_mem_req;
        if (o_if_gnt) bus.if_req_i = 1'b0;
        if (o_d_gnt)  bus.d_req_i = 1'b0;
        step();
        gb = {o_if_gnt, o_d_gnt}; mreq_any |= o_mem_req;
        saw_if_err |= o_if_rv && o_if_err && (o_if_rd == 32'h0);
        saw_d_err  |= o_d_rv && o_d_err && (o_d_rd == 32'h0);
        clear_inputs();
        step();
        saw_if_err |= o_if_rv && o_if_err && (o_if_rd == 32'h0);
        saw_d_err  |= o_d_rv && o_d_err && (o_d_rd == 32'h0);
        chk("t4_mem_req", mreq_any, 0);
        chk("t4_grants", {ga | gb, ga & gb}, 4'b1100);
        chk("t4_errs", {saw_if_err, saw_d_err}, 2'b11);

        // Reset in the cycle after a fetch grant, requests held high.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h10;
        step();
        chk("t5_if_gnt", o_if_gnt, 1);
        rst_n = 1'b0;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_be_i = 4'hF; bus.d_addr_i = 32'h20;
        #3;
        chk_all_zero("t5_midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        chk("t5_no_rvalid", {o_if_rv, o_d_rv}, 0);
`ifdef IMEM_ARB_DATA_PRIORITY_EN
        chk("t5_tie", {o_if_gnt, o_d_gnt}, 2'b01);
`else
        chk("t5_tie", {o_if_gnt, o_d_gnt}, 2'b10);
`endif

        // Randomized traffic obeying the hold-until-grant rule.
        for (int c = 0; c < 3000; c++) begin
            if (!bus.if_req_i || o_if_gnt) begin
                bus.if_req_i  = ($urandom_range(0, 3) != 0);
                bus.if_addr_i = rand_addr();
            end
            if (!bus.d_req_i || o_d_gnt) begin
                bus.d_req_i   = ($urandom_range(0, 3) != 0);
                bus.d_we_i    = 1'($urandom);
                bus.d_be_i    = 4'($urandom);
                bus.d_addr_i  = rand_addr();
                bus.d_wdata_i = $urandom;
            end
            step();
        end
        clear_inputs();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-ported, byte-addressed program memory between the instruction-fetch requester (read-only) and the load/store requester (read/write with byte enables).
- Sits between the core front-end/LSU and the memory.
- Arbitrates per cycle with a registered round-robin pointer.
- Tracks the one in-flight access and routes the 1-cycle-latency read data back to the owner.
- Returns an error response, without touching memory, for out-of-range addresses.

Parameters:
- ADDR_W, 32, requester/memory address width in bits
- MEM_BYTES, 1024, memory size in bytes; the highest legal word access starts at MEM_BYTES-4

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- if_req_i  input  1  fetch request
- if_addr_i  input  ADDR_W  fetch byte address
- if_gnt_o  output  1  fetch request accepted this cycle
- if_rvalid_o  output  1  fetch response valid
- if_rdata_o  output  32  fetch data, little-endian word
- if_err_o  output  1  fetch response is an error
- d_req_i  input  1  data request
- d_we_i  input  1  1 = write, 0 = read
- d_be_i  input  4  byte enables
- d_addr_i  input  ADDR_W  data byte address
- d_wdata_i  input  32  write data
- d_gnt_o  output  1  data request accepted
- d_rvalid_o  output  1  data response valid (reads and writes)
- d_rdata_o  output  32  read data
- d_err_o  output  1  data response is an error
- mem_req_o  output  1  memory access strobe
- mem_we_o  output  1  memory write
- mem_be_o  output  4  memory byte enables
- mem_addr_o  output  ADDR_W  memory byte address
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  memory read data, valid the cycle after mem_req_o

Behaviour:
- Grant logic:
  - Grants are combinational from the requests and the registered pointer last_d.
  - At most one grant per cycle; a new grant is allowed every cycle (fully pipelined, one access per cycle).
- Arbitration:
  - Only one requester asserting: it is granted.
  - Both asserting: if last_d = 1, fetch wins; otherwise data wins.
  - On every grant, last_d updates on the clock edge: 1 if data was granted, 0 if fetch was granted.
- Range check:
  - Address is out of range if addr > MEM_BYTES-4.
  - An out-of-range request is still granted, but mem_req_o stays 0.
  - The next cycle returns rvalid=1 and err=1 to that requester, with rdata = 0.
- Memory drive:
  - In-range fetch: mem_req_o=1, mem_we_o=0, mem_be_o=4'hF, mem_addr_o = if_addr_i.
  - In-range data: mem_* mirror the d_* inputs.
  - Idle: all mem_* outputs are 0.
  - Unaligned addresses are passed through unchanged; the memory handles byte addressing.
- Response stage:
  - Registers owner (none/fetch/data) and err at grant.
  - The cycle after a grant, that owner's rvalid=1.
  - rdata = mem_rdata_i for in-range reads.
  - Data writes produce rvalid=1 with rdata=0 (write acknowledge).
  - The other requester's rvalid, rdata and err are 0.
- Response latency: exactly 1 cycle after grant. There is no response back-pressure.
- Requester rules:
  - A requester holds req and its payload until gnt.
  - A requester may re-request in the cycle its previous response arrives.
- Reset:
  - All outputs are 0, owner = none, last_d = 1 (fetch wins the first tie).
  - Asynchronous reset mid-access discards the in-flight response; no rvalid follows reset release.
- Simultaneous events: a grant and the previous access's response in the same cycle is normal pipelined operation; both proceed.

Optional Feature:
- Macro: IMEM_ARB_DATA_PRIORITY_EN
- Defined:
  - Fixed priority; data always wins a tie.
  - last_d is not implemented.
  - Fetch can starve while d_req_i is held high.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then fetch only at addr 0 with memory word 0x00402103 -> if_gnt_o=1 in cycle 0; if_rvalid_o=1 and if_rdata_o=0x00402103 in cycle 1; d_* outputs stay 0.
- Both requesting continuously, fetch addr 4, data read addr 8 -> grants alternate F,D,F,D starting with F; responses alternate correspondingly, each one cycle after its grant.
- Data write d_be_i=4'b0011, d_addr_i=0x30, d_wdata_i=0xA5A5_1234 -> mem_we_o=1, mem_be_o=4'h3, mem_addr_o=0x30 in the grant cycle; next cycle d_rvalid_o=1, d_rdata_o=0.
- Fetch at 0x3FD and data at 0x400 (MEM_BYTES=1024) -> both granted on successive cycles; mem_req_o=0 in both cycles; each gets rvalid=1, err=1, rdata=0.
- Assert rst_n_i low in the cycle after a fetch grant -> all outputs 0 immediately; no if_rvalid_o after release; first tie after release is won by fetch.
- IMEM_ARB_DATA_PRIORITY_EN defined, both requesting for 4 cycles -> d_gnt_o=1 every cycle, if_gnt_o=0 throughout.
